// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
// Transmit frame sequencer for the UART core. Serialises one byte as
// start bit, 5..8 data bits LSB first, optional parity bit and 1 or 2
// stop bits, paced by the baud generator's 16x oversample enable. Drives
// the external serial parity generator (clear / sample strobe / data) and
// reads its running XOR back to form the parity bit.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick16     16x baud enable, one clk wide
//   wr         write strobe, accepted only while busy=0
//   din        transmit byte
//   word_len   data bit count: 00=5, 01=6, 10=7, 11=8
//   parity_en  parity bit present
//   even_par   1 = even parity, 0 = odd parity
//   stick_par  stick parity (parity bit = ~even_par)
//   stop2      two stop bits when 1
//   break_ctl  forces txd low while high (sequencing unaffected)
//   par_q      running XOR from the parity generator
//   par_srst   parity generator clear (one clk at frame start)
//   par_sd     parity generator sample strobe (first clk of each data bit)
//   par_d      parity generator data bit
//   txd        serial output
//   busy       high from wr acceptance until the frame ends
//   done       one-clk pulse at the end of the frame

module uart_tx_frame_ctrl #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick16,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic [1:0] word_len,
    input  logic       parity_en,
    input  logic       even_par,
    input  logic       stick_par,
    input  logic       stop2,
    input  logic       break_ctl,
    input  logic       par_q,
    output logic       par_srst,
    output logic       par_sd,
    output logic       par_d,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] tick_cnt_q,  tick_cnt_d;
    logic [2:0] bit_idx_q,   bit_idx_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [1:0] word_len_q,  word_len_d;
    logic       parity_en_q, parity_en_d;
    logic       even_par_q,  even_par_d;
    logic       stick_par_q, stick_par_d;
    logic       stop2_q,     stop2_d;
    logic       par_bit_q,   par_bit_d;
    logic       txd_q,       txd_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       par_srst_q,  par_srst_d;
    logic       par_sd_q,    par_sd_d;
    logic       par_d_q,     par_d_d;

    logic       bit_end;
    logic [2:0] last_idx;
    logic       line_d;

    assign last_idx = {1'b0, word_len_q} + 3'd4;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        word_len_d  = word_len_q;
        parity_en_d = parity_en_q;
        even_par_d  = even_par_q;
        stick_par_d = stick_par_q;
        stop2_d     = stop2_q;
        par_bit_d   = par_bit_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        par_srst_d  = 1'b0;
        par_sd_d    = 1'b0;
        par_d_d     = par_d_q;
        bit_end     = 1'b0;
        line_d      = 1'b1;

        // Tick counter only runs inside a frame; a bit end clears it,
        // so every state/bit change starts from zero.
        if (state_q != S_IDLE && tick16) begin
            if (tick_cnt_q == LAST_TICK) begin
                bit_end    = 1'b1;
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 4'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr) begin
                    shreg_d     = din;
                    word_len_d  = word_len;
                    parity_en_d = parity_en;
                    even_par_d  = even_par;
                    stick_par_d = stick_par;
                    stop2_d     = stop2;
                    tick_cnt_d  = '0;
                    bit_idx_d   = '0;
                    busy_d      = 1'b1;
                    par_srst_d  = 1'b1;
                    state_d     = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    par_sd_d  = 1'b1;
                    par_d_d   = shreg_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == last_idx) begin
                        bit_idx_d = '0;
                        if (parity_en_q) begin
                            // par_q already holds every data bit: the last
                            // strobe was a full bit time ago.
                            if (stick_par_q) begin
                                par_bit_d = ~even_par_q;
                            end else if (even_par_q) begin
                                par_bit_d = par_q;
                            end else begin
                                par_bit_d = ~par_q;
                            end
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        par_sd_d  = 1'b1;
                        par_d_d   = shreg_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd1;
                    end else begin
                        state_d   = S_IDLE;
                        bit_idx_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Line level is derived from the next-state registers so txd is
        // itself a flop yet changes on the same edge as the state.
        unique case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shreg_d[0];
            S_PARITY: line_d = par_bit_d;
            default:  line_d = 1'b1;
        endcase

        txd_d = line_d & ~break_ctl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            word_len_q  <= '0;
            parity_en_q <= 1'b0;
            even_par_q  <= 1'b0;
            stick_par_q <= 1'b0;
            stop2_q     <= 1'b0;
            par_bit_q   <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            par_srst_q  <= 1'b0;
            par_sd_q    <= 1'b0;
            par_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            word_len_q  <= word_len_d;
            parity_en_q <= parity_en_d;
            even_par_q  <= even_par_d;
            stick_par_q <= stick_par_d;
            stop2_q     <= stop2_d;
            par_bit_q   <= par_bit_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            par_srst_q  <= par_srst_d;
            par_sd_q    <= par_sd_d;
            par_d_q     <= par_d_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign par_srst = par_srst_q;
    assign par_sd   = par_sd_q;
    assign par_d    = par_d_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl with a behavioural serial parity
// generator closing the par_* loop.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick16;
    logic       wr;
    logic [7:0] din;
    logic [1:0] word_len;
    logic       parity_en;
    logic       even_par;
    logic       stick_par;
    logic       stop2;
    logic       break_ctl;
    logic       par_q;
    logic       par_srst;
    logic       par_sd;
    logic       par_d;
    logic       txd;
    logic       busy;
    logic       done;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int unsigned srst_cnt = 0;
    int unsigned sd_cnt   = 0;
    int unsigned done_cnt = 0;
    int unsigned both_cnt = 0;
    logic [7:0]  sd_sr    = '0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.TICKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick16    (tick16),
        .wr        (wr),
        .din       (din),
        .word_len  (word_len),
        .parity_en (parity_en),
        .even_par  (even_par),
        .stick_par (stick_par),
        .stop2     (stop2),
        .break_ctl (break_ctl),
        .par_q     (par_q),
        .par_srst  (par_srst),
        .par_sd    (par_sd),
        .par_d     (par_d),
        .txd       (txd),
        .busy      (busy),
        .done      (done)
    );

    // Serial parity generator: clear on par_srst, accumulate on par_sd.
    always @(posedge clk) begin
        if (rst || par_srst) par_q <= 1'b0;
        else if (par_sd)     par_q <= par_q ^ par_d;
    end

    // Pulse monitor; sd_sr collects par_d values, newest in bit 7.
    always @(posedge clk) begin
        if (par_srst) srst_cnt = srst_cnt + 1;
        if (done)     done_cnt = done_cnt + 1;
        if (par_srst && par_sd) both_cnt = both_cnt + 1;
        if (par_sd) begin
            sd_cnt = sd_cnt + 1;
            sd_sr  = {par_d, sd_sr[7:1]};
        end
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        logic exp_txd;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            exp_txd = !break_ctl;
            chk("idle busy", {11'b0, busy}, 12'd0);
            chk("idle done", {11'b0, done}, 12'd0);
            chk("idle txd",  {11'b0, txd},  {11'b0, exp_txd});
        end
    endtask

    // Issues wr on the current cycle and checks the whole frame clk by clk.
    // every: tick16 asserted on every 'every'-th edge after acceptance.
    // poke_at / brk_at / rst_at: sample index for mid-frame events (-1 = none).
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] wl,
                             input logic pen, input logic ev, input logic st, input logic s2,
                             input logic exp_par, input int unsigned every,
                             input int poke_at, input int brk_at, input int rst_at);
        int unsigned n, nb, len, t;
        int unsigned srst0, sd0, done0, both0;
        logic [11:0] bits;
        logic [7:0]  mask;
        logic        exp_txd;
        n = 32'(wl) + 5;
        bits = '0;
        for (int unsigned i = 0; i < n; i++) bits[1 + i] = d[i];
        nb = 1 + n;
        if (pen) begin bits[nb] = exp_par; nb++; end
        bits[nb] = 1'b1; nb++;
        if (s2) begin bits[nb] = 1'b1; nb++; end
        len = every * 16 * nb;

        srst0 = srst_cnt; sd0 = sd_cnt; done0 = done_cnt; both0 = both_cnt;
        din = d; word_len = wl; parity_en = pen; even_par = ev; stick_par = st; stop2 = s2;
        tick16 = 1'b1;
        wr = 1'b1;
        for (int j = 0; j < int'(len); j++) begin
            @(negedge clk);
            t = 32'(j) / every;
            exp_txd = break_ctl ? 1'b0 : bits[t / 16];
            chk($sformatf("%s txd@%0d", tag, j),  {11'b0, txd},  {11'b0, exp_txd});
            chk($sformatf("%s busy@%0d", tag, j), {11'b0, busy}, 12'd1);
            chk($sformatf("%s done@%0d", tag, j), {11'b0, done}, 12'd0);
            if (j == 0) begin
                chk({tag, " srst@0"}, {11'b0, par_srst}, 12'd1);
                wr  = 1'b0;
                din = ~d;
            end
            if (j == 1) chk({tag, " srst@1"}, {11'b0, par_srst}, 12'd0);
            tick16 = ((j + 1) % int'(every)) == 0;
            if (j == poke_at) begin
                wr = 1'b1; din = 8'hAA;
                word_len = ~wl; parity_en = ~pen; even_par = ~ev; stick_par = ~st; stop2 = ~s2;
            end
            if (poke_at >= 0 && j == poke_at + 1) begin
                wr = 1'b0; din = ~d;
                word_len = wl; parity_en = pen; even_par = ev; stick_par = st; stop2 = s2;
            end
            if (j == brk_at) break_ctl = 1'b1;
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk({tag, " rst txd"},    {11'b0, txd},    12'd1);
                chk({tag, " rst busy"},   {11'b0, busy},   12'd0);
                chk({tag, " rst done"},   {11'b0, done},   12'd0);
                chk({tag, " rst par_sd"}, {11'b0, par_sd}, 12'd0);
                rst = 1'b0;
                tick16 = 1'b1;
                repeat (40) @(negedge clk);
                chk({tag, " rst no done"}, 12'(done_cnt - done0), 12'd0);
                chk({tag, " rst sd cnt"},  12'(sd_cnt - sd0),     12'd4);
                chk({tag, " rst idle busy"}, {11'b0, busy}, 12'd0);
                chk({tag, " rst idle txd"},  {11'b0, txd},  12'd1);
                return;
            end
        end
        @(negedge clk);
        exp_txd = !break_ctl;
        chk({tag, " end done"}, {11'b0, done}, 12'd1);
        chk({tag, " end busy"}, {11'b0, busy}, 12'd0);
        chk({tag, " end txd"},  {11'b0, txd},  {11'b0, exp_txd});
        chk({tag, " srst cnt"}, 12'(srst_cnt - srst0), 12'd1);
        chk({tag, " sd cnt"},   12'(sd_cnt - sd0),     12'(n));
        chk({tag, " both cnt"}, 12'(both_cnt - both0), 12'd0);
        mask = 8'hFF >> (8 - n);
        chk({tag, " par_d seq"}, {4'b0, (sd_sr >> (8 - n)) & mask}, {4'b0, d & mask});
    endtask

    initial begin
        rst = 1'b1; tick16 = 1'b1; wr = 1'b0; din = 8'h00; word_len = 2'b11;
        parity_en = 1'b0; even_par = 1'b0; stick_par = 1'b0; stop2 = 1'b0; break_ctl = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset txd",      {11'b0, txd},      12'd1);
        chk("reset busy",     {11'b0, busy},     12'd0);
        chk("reset done",     {11'b0, done},     12'd0);
        chk("reset par_srst", {11'b0, par_srst}, 12'd0);
        chk("reset par_sd",   {11'b0, par_sd},   12'd0);
        chk("reset par_d",    {11'b0, par_d},    12'd0);
        rst = 1'b0;
        idle(3);

        // 8N1 0x55
        run_frame("8N1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, -1, -1);
        idle(2);
        // 7 data bits 1000001 -> XOR 0
        run_frame("7E1_41", 8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, -1, -1);
        idle(2);
        run_frame("7O1_41", 8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1, -1, -1);
        idle(2);
        // stick parity: bit = ~even_par regardless of data XOR (11111 -> 1)
        run_frame("5S2_1F_e1", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, -1, -1, -1);
        idle(2);
        run_frame("5S1_1F_e0", 8'h1F, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, -1, -1, -1);
        idle(2);
        // mid-frame wr of 0xAA plus flipped config, then back-to-back
        // 6O2 (101100 -> XOR 1, odd parity 0) with tick16 every third clk
        run_frame("8N1_3C_poke", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 40, -1, -1);
        run_frame("6O2_2C_b2b", 8'h2C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, -1, -1, -1);
        idle(2);
        // reset in DATA bit 3 (frame bit 4, samples 64..79)
        run_frame("8N1_96_rst", 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, -1, 70);
        // 10100101 -> XOR 0, even parity 0
        run_frame("8E1_A5", 8'hA5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, -1, -1);
        idle(2);
        // break from idle through a whole frame
        break_ctl = 1'b1;
        idle(3);
        run_frame("8N1_55_brk", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, -1, -1);
        idle(2);
        break_ctl = 1'b0;
        idle(2);
        // break asserted mid-frame
        run_frame("8N1_55_brkmid", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 50, -1);
        idle(2);
        break_ctl = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Transmit frame sequencer for the UART core. It takes a byte from the register interface and serialises it as start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. It drives the control inputs (clear, sample strobe, data) of the serial parity generator and reads its result back to form the parity bit. It is timed by the baud generator's 16x oversample enable.

Parameters:
TICKS_PER_BIT, 16, number of tick16 pulses per serial bit; legal range 2..16, so the tick counter is 4 bits.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-high
tick16  in  1  16x baud enable, one clk wide
wr  in  1  write strobe; starts a frame when busy=0
din  in  8  transmit byte
word_len  in  2  data bit count: 00=5, 01=6, 10=7, 11=8
parity_en  in  1  1 = parity bit present
even_par  in  1  1 = even parity, 0 = odd parity
stick_par  in  1  1 = stick parity
stop2  in  1  1 = two stop bits, 0 = one stop bit
break_ctl  in  1  1 = force txd low
par_q  in  1  running XOR from the serial parity generator
par_srst  out  1  parity generator clear
par_sd  out  1  parity generator sample strobe
par_d  out  1  parity generator data bit
txd  out  1  serial output
busy  out  1  high from wr acceptance until the frame ends
done  out  1  one-clk pulse at the end of the frame

Behaviour:
- Reset (synchronous): state=IDLE, txd=1, busy=0, done=0, par_srst=0, par_sd=0, par_d=0, tick counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame; txd=1 and busy=0 after that edge, and no done pulse is produced.
- All outputs are registered.
- Acceptance rules:
  - IDLE with wr=1: latch din into the shift register and latch all config inputs. On the next edge: state=START, busy=1, txd=0, par_srst=1 for exactly one clk.
  - wr while busy=1 is ignored. The frame in flight and its latched config are unchanged.
  - Config inputs changing mid-frame have no effect.
- Bit timing:
  - The tick counter increments on each tick16 and is cleared on every state or bit change.
  - A bit ends on the tick16 at which the counter equals TICKS_PER_BIT-1.
  - Every bit lasts exactly TICKS_PER_BIT tick16 pulses.
- START: txd=0. At bit end go to DATA with bit index 0.
- DATA:
  - txd = shift register bit 0.
  - On the first clk of each data bit: par_sd=1 for one clk, with par_d equal to that bit.
  - At bit end, shift right and increment the index.
  - After the last bit (index = word_len+4) go to PARITY if parity_en=1, else to STOP.
- PARITY: txd is set on entry, from par_q, which is settled because the last strobe was at least TICKS_PER_BIT clks earlier.
  - stick_par=1: txd = ~even_par.
  - stick_par=0, even_par=1: txd = par_q.
  - stick_par=0, even_par=0: txd = ~par_q.
  - At bit end go to STOP.
- STOP: txd=1 for 1 bit, or 2 bits when stop2=1.
  - At the final bit end: state=IDLE, busy=0, done=1 for one clk.
  - A wr in the following clk is accepted, giving back-to-back frames with no idle bit.
- Frame length in tick16 pulses: TICKS_PER_BIT × (1 + N + P + S), where N = data bits, P = parity_en, S = 1 or 2.
- break_ctl=1 forces txd=0 in every state, including IDLE. Sequencing, par_* outputs, busy and done are unaffected.
- tick16=0 freezes the counters. par_srst and the first-clk par_sd are still issued on state/bit entry, independent of tick16.
- par_srst and par_sd are never high in the same clk.

Test Plan:
- 8N1, din=0x55, tick16 every clk: txd sequence 0,1,0,1,0,1,0,1,0,1, each level held 16 clks. busy high for 160 clks, then done pulses once. Exactly 8 par_sd pulses, with par_d values 1,0,1,0,1,0,1,0.
- 7E1, din=0x41 (data bits 1000001, XOR=0): parity bit 0. Repeat with even_par=0: parity bit 1. Check frame length 160 tick16 and that par_srst pulses once right after wr.
- Stick parity, 5 data bits, din=0x1F: with even_par=1 the parity bit is 0; with even_par=0 it is 1, independent of par_q. With stop2=1, the stop interval is 32 tick16.
- wr pulsed mid-frame with din=0xAA: ignored, first frame unchanged. A wr in the clk after done starts a new frame with no gap, and its START begins on the following edge.
- rst asserted during DATA bit 3: on the next edge txd=1, busy=0, no done, par_sd stays low. The next wr starts a full, correct frame.
- break_ctl=1 during IDLE and then mid-frame: txd stays 0 throughout, while busy/done timing is identical to the non-break case.
